// File: rtl/deskew_addr_gen.sv
// deskew_addr_gen
// ----------------------------------------------------------------------------
// Raster-scan BRAM address generator for the deskew datapath. It walks a
// square img_dim x img_dim image, one address per enabled cycle, using only
// incremental arithmetic: the next coordinate (nx, ny) and a linear offset
// are stepped by one, and the address is base + offset.
//
// Optional feature macro: DSQW_ADDR_OVF_EN
//   defined   -> addr_ovf port present: sticky flag raised on any issue whose
//                base + offset carries out of bit ADDR_W-1.
//   undefined -> addr_ovf port and its logic are absent.
//
// Handshake: addr_gen_en is a one-way advance request (no back-pressure).
// When it is sampled high while an address can be issued, the registered
// outputs bram_addr/x_cnt/y_cnt carry that address after the same edge and
// addr_vld marks them valid for exactly that cycle.
//
// Ports
//   clk                 in  clock, rising edge
//   rst_n               in  asynchronous reset, active low
//   sclr                in  synchronous clear/restart, latches img_dim
//   addr_gen_en         in  advance request
//   bram_addr_sel       in  base select (0 = input image, 1 = output image)
//   img_dim             in  image side length in pixels
//   in_img_start_addr   in  input image base address
//   out_img_start_addr  in  output image base address
//   bram_addr           out registered BRAM address
//   addr_vld            out bram_addr/x_cnt/y_cnt valid this cycle
//   x_cnt, y_cnt        out column/row of the current bram_addr
//   last_pix            out pulse with the final address of the frame
//   frame_done          out sticky end-of-frame flag
//   addr_ovf            out sticky address carry-out flag (macro only)
//   dbg_state           out FSM state: 0 = IDLE, 1 = RUN, 2 = DONE
// ----------------------------------------------------------------------------
module deskew_addr_gen #(
    parameter int ADDR_W = 17,
    parameter int DIM_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclr,
    input  logic              addr_gen_en,
    input  logic              bram_addr_sel,
    input  logic [DIM_W-1:0]  img_dim,
    input  logic [ADDR_W-1:0] in_img_start_addr,
    input  logic [ADDR_W-1:0] out_img_start_addr,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              addr_vld,
    output logic [DIM_W-1:0]  x_cnt,
    output logic [DIM_W-1:0]  y_cnt,
    output logic              last_pix,
    output logic              frame_done,
`ifdef DSQW_ADDR_OVF_EN
    output logic              addr_ovf,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   dim_q, dim_d;
    logic [DIM_W-1:0]   nx_q, nx_d;
    logic [DIM_W-1:0]   ny_q, ny_d;
    logic [ADDR_W-1:0]  lin_off_q, lin_off_d;
    logic [ADDR_W-1:0]  bram_addr_q, bram_addr_d;
    logic [DIM_W-1:0]   x_cnt_q, x_cnt_d;
    logic [DIM_W-1:0]   y_cnt_q, y_cnt_d;
    logic               addr_vld_q, addr_vld_d;
    logic               last_pix_q, last_pix_d;
    logic               frame_done_q, frame_done_d;

    logic [ADDR_W-1:0]  base;
    logic [ADDR_W-1:0]  addr_next;
    logic [DIM_W-1:0]   dim_m1;
    logic               at_row_end;
    logic               at_last;
    logic               can_issue;
    logic               issue;

    assign base = bram_addr_sel ? out_img_start_addr : in_img_start_addr;

`ifdef DSQW_ADDR_OVF_EN
    logic [ADDR_W:0]    sum_full;
    logic               carry;
    logic               addr_ovf_q, addr_ovf_d;

    assign sum_full  = {1'b0, base} + {1'b0, lin_off_q};
    assign addr_next = sum_full[ADDR_W-1:0];
    assign carry     = sum_full[ADDR_W];
`else
    // Wraps modulo 2^ADDR_W; the carry is deliberately dropped.
    assign addr_next = base + lin_off_q;
`endif

    // dim_m1 is only meaningful when dim_q > 0, which can_issue guarantees.
    assign dim_m1     = dim_q - DIM_W'(1);
    assign at_row_end = (nx_q == dim_m1);
    assign at_last    = at_row_end && (ny_q == dim_m1);
    assign can_issue  = (state_q == RUN) || ((state_q == IDLE) && (dim_q != '0));
    assign issue      = addr_gen_en && !sclr && can_issue;

    always_comb begin
        state_d      = state_q;
        dim_d        = dim_q;
        nx_d         = nx_q;
        ny_d         = ny_q;
        lin_off_d    = lin_off_q;
        bram_addr_d  = bram_addr_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        // addr_vld/last_pix are single-cycle qualifiers: low unless issuing.
        addr_vld_d   = 1'b0;
        last_pix_d   = 1'b0;
        frame_done_d = frame_done_q;
`ifdef DSQW_ADDR_OVF_EN
        addr_ovf_d   = addr_ovf_q;
`endif

        if (sclr) begin
            state_d      = IDLE;
            dim_d        = img_dim;
            nx_d         = '0;
            ny_d         = '0;
            lin_off_d    = '0;
            frame_done_d = 1'b0;
`ifdef DSQW_ADDR_OVF_EN
            addr_ovf_d   = 1'b0;
`endif
        end else if (addr_gen_en && (state_q == IDLE) && (dim_q == '0)) begin
            // Empty frame: finish without issuing anything.
            state_d      = DONE;
            frame_done_d = 1'b1;
        end else if (issue) begin
            bram_addr_d = addr_next;
            x_cnt_d     = nx_q;
            y_cnt_d     = ny_q;
            addr_vld_d  = 1'b1;
`ifdef DSQW_ADDR_OVF_EN
            if (carry) begin
                addr_ovf_d = 1'b1;
            end
`endif
            if (at_last) begin
                // Counters hold at the final pixel; only sclr restarts.
                state_d      = DONE;
                last_pix_d   = 1'b1;
                frame_done_d = 1'b1;
            end else begin
                state_d   = RUN;
                lin_off_d = lin_off_q + ADDR_W'(1);
                if (at_row_end) begin
                    nx_d = '0;
                    ny_d = ny_q + DIM_W'(1);
                end else begin
                    nx_d = nx_q + DIM_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dim_q        <= '0;
            nx_q         <= '0;
            ny_q         <= '0;
            lin_off_q    <= '0;
            bram_addr_q  <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            addr_vld_q   <= 1'b0;
            last_pix_q   <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef DSQW_ADDR_OVF_EN
            addr_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            dim_q        <= dim_d;
            nx_q         <= nx_d;
            ny_q         <= ny_d;
            lin_off_q    <= lin_off_d;
            bram_addr_q  <= bram_addr_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            addr_vld_q   <= addr_vld_d;
            last_pix_q   <= last_pix_d;
            frame_done_q <= frame_done_d;
`ifdef DSQW_ADDR_OVF_EN
            addr_ovf_q   <= addr_ovf_d;
`endif
        end
    end

    assign bram_addr  = bram_addr_q;
    assign addr_vld   = addr_vld_q;
    assign x_cnt      = x_cnt_q;
    assign y_cnt      = y_cnt_q;
    assign last_pix   = last_pix_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;
`ifdef DSQW_ADDR_OVF_EN
    assign addr_ovf   = addr_ovf_q;
`endif

endmodule

// File: tb/tb_deskew_addr_gen.sv
// Testbench for deskew_addr_gen. Stimulus pushes the expected
// {last_pix, y, x, addr} of every address it requests into exp_q; the
// monitor pops and compares whenever addr_vld is seen high.
module tb_deskew_addr_gen;

    localparam int ADDR_W = 17;
    localparam int DIM_W  = 9;
    localparam int EXP_W  = 1 + DIM_W + DIM_W + ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              sclr;
    logic              addr_gen_en;
    logic              bram_addr_sel;
    logic [DIM_W-1:0]  img_dim;
    logic [ADDR_W-1:0] in_img_start_addr;
    logic [ADDR_W-1:0] out_img_start_addr;
    logic [ADDR_W-1:0] bram_addr;
    logic              addr_vld;
    logic [DIM_W-1:0]  x_cnt;
    logic [DIM_W-1:0]  y_cnt;
    logic              last_pix;
    logic              frame_done;
    logic [1:0]        dbg_state;
`ifdef DSQW_ADDR_OVF_EN
    logic              addr_ovf;
`endif

    logic [EXP_W-1:0]  exp_q[$];
    int                n_cmp;
    int                n_fail;

    deskew_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .sclr               (sclr),
        .addr_gen_en        (addr_gen_en),
        .bram_addr_sel      (bram_addr_sel),
        .img_dim            (img_dim),
        .in_img_start_addr  (in_img_start_addr),
        .out_img_start_addr (out_img_start_addr),
        .bram_addr          (bram_addr),
        .addr_vld           (addr_vld),
        .x_cnt              (x_cnt),
        .y_cnt              (y_cnt),
        .last_pix           (last_pix),
        .frame_done         (frame_done),
`ifdef DSQW_ADDR_OVF_EN
        .addr_ovf           (addr_ovf),
`endif
        .dbg_state          (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [EXP_W-1:0] act,
                       input logic [EXP_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic last, input int y, input int x, input int addr);
        exp_q.push_back({last, DIM_W'(y), DIM_W'(x), ADDR_W'(addr)});
    endtask

    task automatic do_sclr(input int dim);
        sclr        = 1'b1;
        img_dim     = DIM_W'(dim);
        addr_gen_en = 1'b0;
        step();
        sclr        = 1'b0;
    endtask

    // Let the monitor drain the last output, then require an empty queue.
    task automatic drain_chk(input string name);
        @(negedge clk);
        #1;
        chk(name, EXP_W'(exp_q.size()), '0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("last_pix_without_vld", EXP_W'(last_pix & ~addr_vld), '0);
            if (addr_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_addr", {last_pix, y_cnt, x_cnt, bram_addr}, '1);
                end else begin
                    chk("addr_stream", {last_pix, y_cnt, x_cnt, bram_addr}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        n_cmp              = 0;
        n_fail             = 0;
        rst_n              = 1'b0;
        sclr               = 1'b0;
        addr_gen_en        = 1'b0;
        bram_addr_sel      = 1'b0;
        img_dim            = '0;
        in_img_start_addr  = '0;
        out_img_start_addr = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", EXP_W'({bram_addr, x_cnt, y_cnt, addr_vld, last_pix, frame_done}), '0);
        chk("reset_state", EXP_W'(dbg_state), EXP_W'(0));
        rst_n = 1'b1;
        step();

        // 1: dim=3 from base 0x100, en held high
        in_img_start_addr = 17'h00100;
        do_sclr(3);
        for (int i = 0; i < 9; i++) push(i == 8, i / 3, i % 3, 'h100 + i);
        addr_gen_en = 1'b1;
        repeat (9) step();
        chk("t1_frame_done_with_last", EXP_W'(frame_done), EXP_W'(1));
        repeat (2) step();   // en stays high in DONE: nothing more may issue
        chk("t1_vld_after", EXP_W'({addr_vld, last_pix, frame_done}), EXP_W'(3'b001));
        chk("t1_state_done", EXP_W'(dbg_state), EXP_W'(2));
        addr_gen_en = 1'b0;
        drain_chk("t1_drain");

        // 2: dim=4, en pattern 1,1,0,0,1
        in_img_start_addr = '0;
        do_sclr(4);
        push(0, 0, 0, 0);
        push(0, 0, 1, 1);
        push(0, 0, 2, 2);
        addr_gen_en = 1'b1; step();
        addr_gen_en = 1'b1; step();
        addr_gen_en = 1'b0; step();
        chk("t2_hold1", EXP_W'({addr_vld, bram_addr, x_cnt, y_cnt}), EXP_W'({1'b0, 17'd1, 9'd1, 9'd0}));
        addr_gen_en = 1'b0; step();
        chk("t2_hold2", EXP_W'({addr_vld, bram_addr, x_cnt, y_cnt}), EXP_W'({1'b0, 17'd1, 9'd1, 9'd0}));
        addr_gen_en = 1'b1; step();
        addr_gen_en = 1'b0;
        drain_chk("t2_drain");

        // 3: dim=2 across the top of the address space
        in_img_start_addr = 17'h1FFFE;
        do_sclr(2);
        push(0, 0, 0, 'h1FFFE);
        push(0, 0, 1, 'h1FFFF);
        push(0, 1, 0, 'h00000);
        push(1, 1, 1, 'h00001);
        addr_gen_en = 1'b1;
        step();
        step();
`ifdef DSQW_ADDR_OVF_EN
        chk("t3_ovf_before_wrap", EXP_W'(addr_ovf), EXP_W'(0));
`endif
        step();
`ifdef DSQW_ADDR_OVF_EN
        chk("t3_ovf_at_wrap", EXP_W'(addr_ovf), EXP_W'(1));
`endif
        step();
`ifdef DSQW_ADDR_OVF_EN
        chk("t3_ovf_sticky", EXP_W'(addr_ovf), EXP_W'(1));
`endif
        addr_gen_en = 1'b0;
        drain_chk("t3_drain");
        do_sclr(2);
        chk("t3_sclr_clears", EXP_W'({frame_done, addr_vld}), '0);
`ifdef DSQW_ADDR_OVF_EN
        chk("t3_ovf_cleared", EXP_W'(addr_ovf), EXP_W'(0));
`endif

        // 4: dim=0 finishes without addresses; dim=1 gives one address
        do_sclr(0);
        addr_gen_en = 1'b1;
        step();
        chk("t4_dim0_done", EXP_W'({frame_done, addr_vld}), EXP_W'(2'b10));
        step();
        chk("t4_dim0_still", EXP_W'({frame_done, addr_vld}), EXP_W'(2'b10));
        addr_gen_en = 1'b0;
        in_img_start_addr = 17'h00100;
        do_sclr(1);
        push(1, 0, 0, 'h100);
        addr_gen_en = 1'b1;
        step();
        chk("t4_dim1_done", EXP_W'(frame_done), EXP_W'(1));
        addr_gen_en = 1'b0;
        step();
        chk("t4_dim1_last_pulse", EXP_W'({last_pix, frame_done}), EXP_W'(2'b01));
        drain_chk("t4_drain");

        // 5: base switch after two issues
        in_img_start_addr  = 17'h00010;
        out_img_start_addr = 17'h00800;
        bram_addr_sel      = 1'b0;
        do_sclr(3);
        push(0, 0, 0, 'h10);
        push(0, 0, 1, 'h11);
        for (int i = 2; i < 9; i++) push(i == 8, i / 3, i % 3, 'h800 + i);
        addr_gen_en = 1'b1;
        repeat (2) step();
        bram_addr_sel = 1'b1;
        repeat (7) step();
        addr_gen_en   = 1'b0;
        bram_addr_sel = 1'b0;
        drain_chk("t5_drain");

        // 6: sclr together with the 5th request restarts with dim=2
        in_img_start_addr = '0;
        do_sclr(3);
        for (int i = 0; i < 4; i++) push(0, i / 3, i % 3, i);
        addr_gen_en = 1'b1;
        repeat (4) step();
        sclr    = 1'b1;
        img_dim = DIM_W'(2);
        step();
        sclr = 1'b0;
        chk("t6_clear_wins", EXP_W'({addr_vld, frame_done}), '0);
        for (int i = 0; i < 4; i++) push(i == 3, i / 2, i % 2, i);
        repeat (4) step();
        chk("t6_done", EXP_W'(frame_done), EXP_W'(1));
        addr_gen_en = 1'b0;
        drain_chk("t6_drain");

        // 7: asynchronous reset mid-frame
        in_img_start_addr = 17'h00100;
        do_sclr(3);
        push(0, 0, 0, 'h100);
        push(0, 0, 1, 'h101);
        addr_gen_en = 1'b1;
        repeat (2) step();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_async_clear", EXP_W'({bram_addr, x_cnt, y_cnt, addr_vld, last_pix, frame_done}), '0);
        chk("t7_queue_empty", EXP_W'(exp_q.size()), '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        // dim was cleared by reset, so a request now ends an empty frame
        step();
        chk("t7_dim_cleared", EXP_W'({frame_done, addr_vld}), EXP_W'(2'b10));
        addr_gen_en = 1'b0;
        drain_chk("t7_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/deskew_addr_gen.md
# deskew_addr_gen

Raster-scan address generator in the deskew datapath, directly downstream of the deskew control path. It consumes `sclr`, `addr_gen_en`, `bram_addr_sel`, `img_dim` and the two image start addresses. It produces the BRAM address stream plus the `x_cnt`/`y_cnt` coordinates that the control FSM monitors. It walks a square `img_dim` x `img_dim` image at one address per enabled cycle using incremental arithmetic, with no multiplier.

## Interface
- `ADDR_W`, 17: BRAM address width; must match the start-address width.
- `DIM_W`, 9: coordinate and dimension width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `sclr` in 1: synchronous clear and restart; highest priority after reset.
- `addr_gen_en` in 1: advance request; one address is issued per cycle while high.
- `bram_addr_sel` in 1: base select, 0 = `in_img_start_addr`, 1 = `out_img_start_addr`; sampled with `addr_gen_en`.
- `img_dim` in DIM_W: image side length in pixels; latched on `sclr`.
- `in_img_start_addr` in ADDR_W: input image base.
- `out_img_start_addr` in ADDR_W: output image base.
- `bram_addr` out ADDR_W: registered address.
- `addr_vld` out 1: `bram_addr`, `x_cnt` and `y_cnt` are valid this cycle.
- `x_cnt` out DIM_W: column of the current `bram_addr`.
- `y_cnt` out DIM_W: row of the current `bram_addr`.
- `last_pix` out 1: pulse that accompanies the final address of the frame.
- `frame_done` out 1: sticky end-of-frame flag; cleared by `sclr`.
- `addr_ovf` out 1: sticky base+offset carry-out flag. Present only with `DSQW_ADDR_OVF_EN`.

## Operation
- Internal state:
  - `dim_q` (DIM_W).
  - Next-coordinate registers `nx`, `ny`.
  - Linear offset `lin_off` (ADDR_W).
  - FSM with states IDLE, RUN, DONE.
- Reset (`rst_n`=0) takes effect asynchronously and clears every register to 0, so all outputs read 0. The FSM goes to IDLE.
- `sclr`=1:
  - Latches `dim_q`<=`img_dim`.
  - Clears `nx`, `ny`, `lin_off`, `addr_vld`, `last_pix`, `frame_done` and `addr_ovf`.
  - Sets the FSM to IDLE.
  - Ignores `addr_gen_en` in that cycle.
- After reset, `dim_q`=0, so the block must receive `sclr` before its first frame.
- IDLE:
  - `addr_gen_en`=1 with `dim_q`=0: go to DONE and set `frame_done`. No address is issued.
  - `addr_gen_en`=1 with `dim_q`>0: issue an address as in RUN and enter RUN, or DONE if `dim_q`=1.
- RUN, issue cycle (`addr_gen_en`=1):
  - `bram_addr`<=base+`lin_off`, modulo 2^ADDR_W.
  - `x_cnt`<=`nx`, `y_cnt`<=`ny`, `addr_vld`<=1.
  - Then `lin_off`+=1.
  - If `nx`=`dim_q`-1: `nx`<=0 and `ny`+=1. Otherwise `nx`+=1.
- Last pixel (`nx`=`ny`=`dim_q`-1 at issue): `last_pix`<=1 and `frame_done`<=1 on the same edge. The FSM goes to DONE and the counters hold.
- `addr_gen_en`=0 outside DONE: `addr_vld`<=0 and `last_pix`<=0. `bram_addr`, `x_cnt`, `y_cnt` and the counters hold.
- DONE:
  - `addr_gen_en` is ignored and `addr_vld` is 0.
  - `frame_done` stays 1 until `sclr` or reset.
  - `last_pix` is 1 only for the single cycle following the final issue.
- `bram_addr_sel` is evaluated per issue cycle. Changing it mid-frame switches the base immediately, and `lin_off` continues.
- Arithmetic:
  - Address wraps mod 2^17; a carry out is not an error without the macro.
  - Frame length is `dim_q`^2 addresses, at most 511^2 = 261121. `lin_off` therefore wraps for `dim_q`>362, and the wrap is permitted.

## Timing
- Latency is 1 cycle: `addr_gen_en` sampled high at edge N gives `addr_vld`/`bram_addr` valid after edge N.
- Throughput is 1 address per cycle with no bubbles while enabled.
- `x_cnt`, `y_cnt`, `bram_addr`, `addr_vld`, `last_pix` and `frame_done` are all registered and change on the same edge.
- A frame of D>0 pixels with `addr_gen_en` held high from IDLE takes D^2 cycles from the first `addr_vld` to `last_pix`.
- When `sclr` and `addr_gen_en` are high together, the clear wins. The first address is issued on the next enabled cycle.
- Reset asserted mid-frame clears the block immediately. No partial state survives.

## Configuration
- `DSQW_ADDR_OVF_EN` defined:
  - The `addr_ovf` port exists.
  - It is set on any issue whose base+`lin_off` produces a carry out of bit ADDR_W-1.
  - It is sticky until `sclr` or reset.
  - Address wrap behaviour is unchanged.
- `DSQW_ADDR_OVF_EN` undefined: the port and its logic are absent.

## Test plan
- `sclr` with dim=3, base_in=0x00100, sel=0, then en held high -> `bram_addr` 0x100..0x108 on 9 consecutive cycles. (x,y) sequence is (0,0),(1,0),(2,0),(0,1)…(2,2). `last_pix`+`frame_done` with 0x108, `addr_vld`=0 after.
- dim=4 with en toggled 1,1,0,0,1 -> addresses 0,1, held for 2 cycles with `addr_vld`=0, then 2. Coordinates follow; no skipped or duplicated address.
- dim=2, base_in=0x1FFFE -> 0x1FFFE,0x1FFFF,0x00000,0x00001. With the macro, `addr_ovf` rises with 0x00000 and stays high until `sclr`.
- dim=0 then en=1 -> `frame_done`=1 the next cycle, `addr_vld` never 1. dim=1 -> one address at base with `last_pix`=1.
- dim=3, sel toggled 0→1 after 2 issues (base_in=0x10, base_out=0x800) -> 0x10,0x11,0x802,0x803…
- `sclr` at the 5th issue of dim=3 with a new dim=2 -> restart at offset 0 with 4 addresses. A separate `rst_n` pulse mid-frame -> all outputs 0 asynchronously.
